// File: rtl/param_shift_engine.sv
// param_shift_engine: loadable register performing amt single-bit rotate/shift steps per operation.
// Define ARITH_SHIFT_EN to make op 11 an arithmetic (sign-replicating) shift right.
module param_shift_engine #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             serial_out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, step_q;
  logic             so_q, so_d, done_q, done_d, left, msb_fill, step_so;
  assign left = ~op_q[0];
`ifdef ARITH_SHIFT_EN
  assign msb_fill = op_q[1] ? q_q[WIDTH-1] : q_q[0];
`else
  assign msb_fill = ~op_q[1] & q_q[0];
`endif
  // op[1] selects the non-wrapping variants; left shift always fills with 0
  assign step_q  = left ? {q_q[WIDTH-2:0], ~op_q[1] & q_q[WIDTH-1]} : {msb_fill, q_q[WIDTH-1:1]};
  assign step_so = left ? q_q[WIDTH-1] : q_q[0];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    so_d    = so_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (!load_n) q_d = data_in;
      else if (start) begin
        done_d  = (amt == '0);
        state_d = (amt == '0) ? IDLE : RUN;
        op_d    = op;
        cnt_d   = amt;
      end
    end else begin
      q_d     = step_q;
      so_d    = step_so;
      cnt_d   = cnt_q - 1'b1;
      done_d  = (cnt_q == AMT_W'(1));
      state_d = (cnt_q == AMT_W'(1)) ? IDLE : RUN;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end
  assign q          = q_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign serial_out = so_q;
endmodule
